// File: rtl/smoldvi_pkg.sv
// Shared definitions for the smoldvi pixel pipeline.
// Pattern selector codes used by the test-pattern source.
package smoldvi_pkg;

  typedef enum logic [1:0] {
    PAT_GRADIENT = 2'd0,
    PAT_BARS     = 2'd1,
    PAT_CHECKER  = 2'd2,
    PAT_SOLID    = 2'd3
  } pattern_e;

endpackage

// File: rtl/smoldvi_pattern_src_if.sv
// Pixel bus between the pattern source (master) and the smoldvi encoder (slave).
// The encoder pulls pixels with rgb_rdy; every pixel on the bus is always valid.
interface smoldvi_pattern_src_if;

  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic       rgb_rdy;
  logic [9:0] x;
  logic [8:0] y;
  logic [7:0] frame;
  logic       frame_start;

  modport master (
    output r, g, b, x, y, frame, frame_start,
    input  rgb_rdy
  );

  modport slave (
    input  r, g, b, x, y, frame, frame_start,
    output rgb_rdy
  );

endinterface

// File: rtl/smoldvi_pattern_colour.sv
// Combinational colour function of raster position, frame, bar index and pattern.
// Only the low coordinate bits matter to any pattern, so only those are passed in.
module smoldvi_pattern_colour
  import smoldvi_pkg::*;
#(
  parameter int CHECK_LOG2 = 5
) (
  input  logic [7:0]  x_lo,
  input  logic [7:0]  y_lo,
  input  logic [7:0]  frame,
  input  logic [2:0]  bar,
  input  pattern_e    mode,
  input  logic [23:0] solid,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b
);

  logic check_white;

  assign check_white = x_lo[CHECK_LOG2] ^ y_lo[CHECK_LOG2];

  always_comb begin
    r = '0;
    g = '0;
    b = '0;
    case (mode)
      PAT_GRADIENT: begin
        r = x_lo + frame;
        g = y_lo + {frame[6:0], 1'b0};
        b = frame;
      end
      // Bar 0 is white, bar 7 is black.
      PAT_BARS: begin
        r = {8{~bar[2]}};
        g = {8{~bar[1]}};
        b = {8{~bar[0]}};
      end
      PAT_CHECKER: {r, g, b} = {24{check_white}};
      PAT_SOLID:   {r, g, b} = solid;
      default:     {r, g, b} = '0;
    endcase
  end

endmodule

// File: rtl/smoldvi_pattern_src.sv
// Test-pattern pixel source feeding the smoldvi encoder: walks the visible raster
// and registers the colour of the next pixel computed from next-state counters.
module smoldvi_pattern_src
  import smoldvi_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int X_STEP     = 2,
  parameter int CHECK_LOG2 = 5
) (
  input  logic                          clk_pix,
  input  logic                          rst_pix,
  input  logic                          en,
  input  logic [1:0]                    mode,
  input  logic [23:0]                   solid_rgb,
  smoldvi_pattern_src_if.master         pix
);

  localparam logic [9:0]  X_LAST   = 10'(H_ACTIVE - X_STEP);
  localparam logic [9:0]  X_INC    = 10'(X_STEP);
  localparam logic [8:0]  Y_LAST   = 9'(V_ACTIVE - 1);
  localparam logic [11:0] BAR_SPAN = 12'(H_ACTIVE);
  localparam logic [11:0] BAR_INC  = 12'(8 * X_STEP);

  logic [9:0]  x_q, x_n;
  logic [8:0]  y_q, y_n;
  logic [7:0]  frame_q, frame_n;
  pattern_e    mode_q, mode_n;
  logic [23:0] solid_q, solid_n;
  logic [2:0]  bar_q, bar_n;
  logic [11:0] bar_acc_q, bar_acc_n, bar_sum;
  logic [7:0]  r_q, g_q, b_q;
  logic [7:0]  r_n, g_n, b_n;
  logic        frame_start_q;

  // bar_acc holds 8*x mod H_ACTIVE, so bar tracks floor(8*x/H_ACTIVE) without a divider.
  always_comb begin
    x_n       = x_q;
    y_n       = y_q;
    frame_n   = frame_q;
    mode_n    = mode_q;
    solid_n   = solid_q;
    bar_n     = bar_q;
    bar_acc_n = bar_acc_q;
    bar_sum   = bar_acc_q + BAR_INC;
    if (!en) begin
      x_n       = '0;
      y_n       = '0;
      bar_n     = '0;
      bar_acc_n = '0;
      mode_n    = pattern_e'(mode);
      solid_n   = solid_rgb;
    end else if (pix.rgb_rdy) begin
      if (x_q == X_LAST) begin
        x_n       = '0;
        bar_n     = '0;
        bar_acc_n = '0;
        if (y_q == Y_LAST) begin
          y_n     = '0;
          frame_n = frame_q + 8'd1;
          mode_n  = pattern_e'(mode);
          solid_n = solid_rgb;
        end else begin
          y_n = y_q + 9'd1;
        end
      end else begin
        x_n = x_q + X_INC;
        if (bar_sum >= BAR_SPAN) begin
          bar_acc_n = bar_sum - BAR_SPAN;
          bar_n     = bar_q + 3'd1;
        end else begin
          bar_acc_n = bar_sum;
        end
      end
    end
  end

  smoldvi_pattern_colour #(
    .CHECK_LOG2 (CHECK_LOG2)
  ) u_colour (
    .x_lo  (x_n[7:0]),
    .y_lo  (y_n[7:0]),
    .frame (frame_n),
    .bar   (bar_n),
    .mode  (mode_n),
    .solid (solid_n),
    .r     (r_n),
    .g     (g_n),
    .b     (b_n)
  );

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      x_q           <= '0;
      y_q           <= '0;
      frame_q       <= '0;
      mode_q        <= PAT_GRADIENT;
      solid_q       <= '0;
      bar_q         <= '0;
      bar_acc_q     <= '0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      frame_start_q <= 1'b1;
    end else begin
      x_q           <= x_n;
      y_q           <= y_n;
      frame_q       <= frame_n;
      mode_q        <= mode_n;
      solid_q       <= solid_n;
      bar_q         <= bar_n;
      bar_acc_q     <= bar_acc_n;
      r_q           <= r_n;
      g_q           <= g_n;
      b_q           <= b_n;
      frame_start_q <= (x_n == '0) && (y_n == '0);
    end
  end

  assign pix.x           = x_q;
  assign pix.y           = y_q;
  assign pix.frame       = frame_q;
  assign pix.r           = r_q;
  assign pix.g           = g_q;
  assign pix.b           = b_q;
  assign pix.frame_start = frame_start_q;

endmodule

// File: doc/smoldvi_pattern_src.md
Name: smoldvi_pattern_src

Overview:
- Pixel source that sits directly upstream of the smoldvi encoder and drives its r/g/b/rgb_rdy interface.
- Replaces ad-hoc counters in FPGA top levels with one reusable generator.
- Walks the visible raster (x, y, frame) and produces one of four selectable test patterns.
- Every pixel is always valid; the downstream encoder pulls pixels with rgb_rdy.

Parameters:
- H_ACTIVE, 640, visible pixels per line in source coordinates; multiple of 8 and of X_STEP.
- V_ACTIVE, 480, visible lines per frame.
- X_STEP, 2, x increment per accepted pixel (2 = horizontal pixel doubling); power of two, ≤ 8.
- CHECK_LOG2, 5, checkerboard square size is 2^CHECK_LOG2 pixels.

Ports:
- clk_pix  in  1  pixel clock.
- rst_pix  in  1  reset, synchronous, active-high.
- en  in  1  run enable; low holds the raster at its origin.
- mode  in  2  pattern select; sampled only at frame boundaries.
- solid_rgb  in  24  {r,g,b} for solid mode; sampled only at frame boundaries.
- rgb_rdy  in  1  encoder accepts the current pixel on this edge.
- r  out  8  current pixel red.
- g  out  8  current pixel green.
- b  out  8  current pixel blue.
- x  out  10  current pixel x coordinate.
- y  out  9  current pixel y coordinate.
- frame  out  8  frame counter, wraps mod 256.
- frame_start  out  1  high while the current pixel is (0,0).

Behaviour:
- One clock (clk_pix). Synchronous, active-high reset (rst_pix); all state is updated only on posedge clk_pix.
- Reset values: x=0, y=0, frame=0, mode_q=0, solid_q=0, r=g=b=0, frame_start=1.
- Invariant at every cycle: {r,g,b} = colour(x, y, frame, mode_q, solid_q). r/g/b are registered; the next-pixel colour is computed from next-state counters, so no combinational path exists from rgb_rdy to r/g/b.
- Advance, on an edge with en=1 and rgb_rdy=1:
  - If x == H_ACTIVE-X_STEP: x←0.
  - Otherwise: x←x+X_STEP.
  - On x wrap: if y == V_ACTIVE-1, then y←0, frame←frame+1, mode_q←mode and solid_q←solid_rgb; otherwise y←y+1.
- rgb_rdy=0: all outputs hold (stall of any length).
- en=0: x←0 and y←0, mode_q/solid_q reload, frame holds, r/g/b recompute for (0,0); rgb_rdy is ignored.
- Patterns (colour function; all arithmetic mod 256):
  - 0 gradient: r=x[7:0]+frame, g=y[7:0]+{frame[6:0],0}, b=frame.
  - 1 bars: bar index i = floor(8*x/H_ACTIVE), tracked with a bar-position counter (no divider). Colour is r={8{~i[2]}}, g={8{~i[1]}}, b={8{~i[0]}}, so bar 0 is white and bar 7 is black.
  - 2 checker: white if x[CHECK_LOG2]^y[CHECK_LOG2], else black.
  - 3 solid: solid_q.
- Mode and solid_rgb changes mid-frame have no visible effect until the frame wrap.
- rst_pix asserted mid-frame: the next edge yields the reset values regardless of en/rgb_rdy.
- rst_pix has priority over en; en has priority over rgb_rdy.

Decomposition:
- Package smoldvi_pkg holds the mode constants (PAT_GRADIENT=0, PAT_BARS=1, PAT_CHECKER=2, PAT_SOLID=3).
- Sub-module smoldvi_pattern_colour: purely combinational colour function of (x, y, frame, bar index, mode, solid). The parent instantiates it once, on the next-state counters, and contains all raster/bar counters and output registers.

Test Plan:
- Reset, en=1, rgb_rdy=1, mode=0: after 1 accept x=2, r=2, g=0, b=0; after 320 accepts x=0, y=1, g=1.
- Full frame (153600 accepts): frame=1, frame_start=1, {r,g,b}={01,02,01}; accept 1 more → frame_start=0.
- rgb_rdy held low 10 cycles at x=100: x, y and r/g/b unchanged throughout; next accept → x=102.
- mode←1 mid-frame: gradient continues until wrap. After wrap, x=0 → FFFFFF, x=80 → FFFF00, x=560 → 000000; mode←2 gives black at (0,0) and white at x=32, y=0.
- mode=3 with solid_rgb=123456 latched at boundary, then solid_rgb←ABCDEF mid-frame: output stays 123456 until the next frame, then ABCDEF.
- rst_pix pulsed at x=200, y=37, frame=5: next cycle all outputs equal the reset values. Separately, en low for 3 cycles → x=0, y=0, frame unchanged, rgb_rdy ignored.
